baccarat_fsm: RTL and testbench
===============================

Name: baccarat_fsm

Overview:
Control state machine for the baccarat table. It sits directly upstream of the card datapath and drives its card-load enables and its bet/balance enables. It consumes the datapath's player score, dealer score and player third card, applies the tableau (third-card) rules, and reports the round outcome on win lights.

Parameters:
CARD_W, 4, width of a card rank (1=A … 10,11,12,13=10/J/Q/K)
SCORE_W, 4, width of a hand score (0..9)

Ports:
slow_clock  input  1  single clock; all state changes on rising edge
reset  input  1  synchronous, active-high; sampled on slow_clock rising edge
start  input  1  level; begins a round when sampled high in IDLE or DONE
pcard3_out  input  CARD_W  player third-card rank from the datapath
pscore_out  input  SCORE_W  player hand score from the datapath
dscore_out  input  SCORE_W  dealer hand score from the datapath
betenabled  output  1  latch bet type/amount
load_pcard1, load_pcard2, load_pcard3  output  1 each  player card-register enables
load_dcard1, load_dcard2, load_dcard3  output  1 each  dealer card-register enables
updatebalanceenable  output  1  commit the new balance
player_win_light  output  1  player won (both lights high on a tie)
dealer_win_light  output  1  dealer won (both lights high on a tie)
round_done  output  1  high in DONE

Behaviour:
- All outputs are Moore outputs decoded from the state register. Reset gives state IDLE with every output 0.
- States, one slow_clock cycle each unless noted:
  - IDLE: wait; start=1 -> BET.
  - BET: betenabled=1 -> DEAL_P1.
  - DEAL_P1: load_pcard1 -> DEAL_D1.
  - DEAL_D1: load_dcard1 -> DEAL_P2.
  - DEAL_P2: load_pcard2 -> DEAL_D2.
  - DEAL_D2: load_dcard2 -> CHECK.
- Scores are valid one cycle after the corresponding load. CHECK therefore sees the two-card scores.
- CHECK:
  - pscore_out>=8 or dscore_out>=8 (natural) -> RESULT.
  - else pscore_out<=5 -> DEAL_P3.
  - else (player stands) -> dscore_out<=5 ? DEAL_D3 : RESULT.
- DEAL_P3: load_pcard3 -> BANKER.
- BANKER: uses third-card value v = (pcard3_out>=10) ? 0 : pcard3_out. The dealer draws (-> DEAL_D3) when any of these holds:
  - d<=2
  - d==3 and v!=8
  - d==4 and v in 2..7
  - d==5 and v in 4..7
  - d==6 and v in 6..7
- Otherwise (including d==7) BANKER -> RESULT.
- DEAL_D3: load_dcard3 -> RESULT.
- RESULT: waits one cycle for final scores, then registers the lights:
  - player_win_light = p>=d
  - dealer_win_light = d>=p
  - Next state UPDATE.
- UPDATE: updatebalanceenable=1 -> DONE.
- DONE: lights and round_done held; start=1 -> BET (new round).
- Each load/enable output is a single-cycle pulse. No two loads are ever asserted together.
- Lights clear on entry to BET.
- start is ignored in every state except IDLE and DONE. Holding start high through DONE begins back-to-back rounds.
- Out-of-range inputs (score>9, rank 0 or >13) are not checked. Rank 0 is treated as v=0.
- Reset mid-round returns to IDLE within one cycle with all outputs 0. The datapath's own reset clears its cards.

Optional Feature:
BACCARAT_STEP_EN.
- Defined: adds input step (1 bit). Each of BET, every DEAL_*, CHECK, BANKER, RESULT and UPDATE holds, with its output held asserted, until step is sampled high, then transitions. Because the enables are held across the wait, load/enable outputs are no longer single-cycle pulses in this build.
- Undefined: no step port; behaviour is exactly as above.

Decomposition:
- Shared package baccarat_pkg holds:
  - state enum
  - CARD_W, SCORE_W
  - NATURAL_MIN=8, PLAYER_STAND_MIN=6
  - function third_card_value(rank)
- One sub-module is natural: baccarat_banker_rule, combinational (dscore, v) -> draw.
- All state and sequencing stays in baccarat_fsm.

Test Plan:
- Natural: CHECK sees p=8, d=3. Expect no load_pcard3/load_dcard3, then RESULT, player_win_light=1, dealer_win_light=0, one updatebalanceenable pulse, round_done.
- Player stands, dealer draws: CHECK sees p=6, d=4. Expect no load_pcard3, load_dcard3 pulse. With final d=9, expect dealer_win_light=1 only.
- Banker rule table: at BANKER, sweep d=3..6 against pcard3_out in {8,4,6,12}.
  - d=3,v=8: stand
  - d=4,rank 12 (v=0): stand
  - d=5,v=4: draw
  - d=6,v=6: draw
- Tie: final p=d=7. Expect both lights=1 in DONE and a single updatebalanceenable pulse.
- Reset mid-round: assert reset during DEAL_P2. Next cycle, all outputs 0 and state IDLE. start with reset low -> betenabled one cycle later.
- Back-to-back rounds: hold start=1 through DONE. Expect lights clear in BET, and exactly one pulse of each load per round.

Source files
------------

// File: rtl/baccarat_pkg.sv
// Shared types and constants for the baccarat table controller.
// Optional build macro: BACCARAT_STEP_EN (adds a single-step hold input to the FSM).
package baccarat_pkg;

  localparam int CARD_W           = 4;  // card rank 1..13
  localparam int SCORE_W          = 4;  // hand score 0..9
  localparam int NATURAL_MIN      = 8;  // two-card 8 or 9 ends the deal
  localparam int PLAYER_STAND_MIN = 6;  // two-card 6 or 7 stands (dealer uses the same cut)

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_BET     = 4'd1,
    S_DEAL_P1 = 4'd2,
    S_DEAL_D1 = 4'd3,
    S_DEAL_P2 = 4'd4,
    S_DEAL_D2 = 4'd5,
    S_CHECK   = 4'd6,
    S_DEAL_P3 = 4'd7,
    S_BANKER  = 4'd8,
    S_DEAL_D3 = 4'd9,
    S_RESULT  = 4'd10,
    S_UPDATE  = 4'd11,
    S_DONE    = 4'd12
  } state_e;

  // Baccarat value of a rank: 10/J/Q/K count as 0; rank 0 also falls out as 0.
  function automatic logic [SCORE_W-1:0] third_card_value(input logic [CARD_W-1:0] rank);
    if (rank >= CARD_W'(10)) return '0;
    return SCORE_W'(rank);
  endfunction

endpackage

// File: rtl/baccarat_banker_rule.sv
// Tableau rule for the dealer's third card: given the dealer's two-card
// score and the value of the player's third card, decide whether to draw.
module baccarat_banker_rule
  import baccarat_pkg::*;
(
  input  logic [SCORE_W-1:0] i_dscore,
  input  logic [SCORE_W-1:0] i_value,
  output logic               o_draw
);

  // Draw decision by dealer score; 7 and above always stands.
  always_comb begin
    o_draw = 1'b0;
    case (i_dscore)
      SCORE_W'(0), SCORE_W'(1), SCORE_W'(2):
        o_draw = 1'b1;
      SCORE_W'(3):
        o_draw = (i_value != SCORE_W'(8));
      SCORE_W'(4):
        o_draw = (i_value >= SCORE_W'(2)) && (i_value <= SCORE_W'(7));
      SCORE_W'(5):
        o_draw = (i_value >= SCORE_W'(4)) && (i_value <= SCORE_W'(7));
      SCORE_W'(6):
        o_draw = (i_value >= SCORE_W'(6)) && (i_value <= SCORE_W'(7));
      default:
        o_draw = 1'b0;
    endcase
  end

endmodule

// File: rtl/baccarat_fsm.sv
// Baccarat table control FSM: sequences the deal, applies the third-card
// tableau, and registers the win lights. All enables are Moore decodes of
// the state register; dbg_state exposes that register directly.
// Optional build macro: BACCARAT_STEP_EN adds input 'step'; every working
// state then holds (output asserted) until step is sampled high.
//
// Handshake: start is a level sampled only in IDLE/DONE; when step exists it
// acts as a per-state ready, and the state advances on the edge where it is 1.
module baccarat_fsm
  import baccarat_pkg::*;
(
  input  logic               slow_clock,
  input  logic               reset,
  input  logic               start,
`ifdef BACCARAT_STEP_EN
  input  logic               step,
`endif
  input  logic [CARD_W-1:0]  pcard3_out,
  input  logic [SCORE_W-1:0] pscore_out,
  input  logic [SCORE_W-1:0] dscore_out,
  output logic               betenabled,
  output logic               load_pcard1,
  output logic               load_pcard2,
  output logic               load_pcard3,
  output logic               load_dcard1,
  output logic               load_dcard2,
  output logic               load_dcard3,
  output logic               updatebalanceenable,
  output logic               player_win_light,
  output logic               dealer_win_light,
  output logic               round_done,
  output state_e             dbg_state
);

  state_e               r_state;
  state_e               w_next_state;
  logic                 w_advance;
  logic                 w_banker_draw;
  logic [SCORE_W-1:0]   w_third_value;
  logic                 r_player_win;
  logic                 r_dealer_win;

`ifdef BACCARAT_STEP_EN
  assign w_advance = step;
`else
  assign w_advance = 1'b1;
`endif

  assign w_third_value = third_card_value(pcard3_out);

  baccarat_banker_rule u_banker_rule (
    .i_dscore (dscore_out),
    .i_value  (w_third_value),
    .o_draw   (w_banker_draw)
  );

  // State register.
  always_ff @(posedge slow_clock) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  // Next-state logic: deal sequence, natural/stand checks, banker tableau.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:    if (start)     w_next_state = S_BET;
      S_BET:     if (w_advance) w_next_state = S_DEAL_P1;
      S_DEAL_P1: if (w_advance) w_next_state = S_DEAL_D1;
      S_DEAL_D1: if (w_advance) w_next_state = S_DEAL_P2;
      S_DEAL_P2: if (w_advance) w_next_state = S_DEAL_D2;
      S_DEAL_D2: if (w_advance) w_next_state = S_CHECK;
      S_CHECK: begin
        if (w_advance) begin
          if ((pscore_out >= SCORE_W'(NATURAL_MIN)) || (dscore_out >= SCORE_W'(NATURAL_MIN)))
            w_next_state = S_RESULT;
          else if (pscore_out < SCORE_W'(PLAYER_STAND_MIN))
            w_next_state = S_DEAL_P3;
          else if (dscore_out < SCORE_W'(PLAYER_STAND_MIN))
            w_next_state = S_DEAL_D3;
          else
            w_next_state = S_RESULT;
        end
      end
      S_DEAL_P3: if (w_advance) w_next_state = S_BANKER;
      S_BANKER:  if (w_advance) w_next_state = w_banker_draw ? S_DEAL_D3 : S_RESULT;
      S_DEAL_D3: if (w_advance) w_next_state = S_RESULT;
      S_RESULT:  if (w_advance) w_next_state = S_UPDATE;
      S_UPDATE:  if (w_advance) w_next_state = S_DONE;
      S_DONE:    if (start)     w_next_state = S_BET;
      default:                  w_next_state = S_IDLE;
    endcase
  end

  // Win lights: cleared on entry to BET, captured from final scores leaving RESULT.
  always_ff @(posedge slow_clock) begin
    if (reset) begin
      r_player_win <= 1'b0;
      r_dealer_win <= 1'b0;
    end else if (w_next_state == S_BET) begin
      r_player_win <= 1'b0;
      r_dealer_win <= 1'b0;
    end else if ((r_state == S_RESULT) && w_advance) begin
      r_player_win <= (pscore_out >= dscore_out);
      r_dealer_win <= (dscore_out >= pscore_out);
    end
  end

  // Moore output decode: one enable per state, nothing asserted by default.
  always_comb begin
    betenabled          = 1'b0;
    load_pcard1         = 1'b0;
    load_pcard2         = 1'b0;
    load_pcard3         = 1'b0;
    load_dcard1         = 1'b0;
    load_dcard2         = 1'b0;
    load_dcard3         = 1'b0;
    updatebalanceenable = 1'b0;
    round_done          = 1'b0;
    case (r_state)
      S_BET:     betenabled          = 1'b1;
      S_DEAL_P1: load_pcard1         = 1'b1;
      S_DEAL_D1: load_dcard1         = 1'b1;
      S_DEAL_P2: load_pcard2         = 1'b1;
      S_DEAL_D2: load_dcard2         = 1'b1;
      S_DEAL_P3: load_pcard3         = 1'b1;
      S_DEAL_D3: load_dcard3         = 1'b1;
      S_UPDATE:  updatebalanceenable = 1'b1;
      S_DONE:    round_done          = 1'b1;
      default: ;
    endcase
  end

  assign player_win_light = r_player_win;
  assign dealer_win_light = r_dealer_win;
  assign dbg_state        = r_state;

endmodule

// File: tb/tb_baccarat_fsm.sv
// Bench for baccarat_fsm: a small datapath stand-in feeds scores, a driver
// issues rounds and queues the expected per-round record, and a monitor
// builds the observed record when round_done rises and compares.
module tb_baccarat_fsm;
  import baccarat_pkg::*;

  localparam int W = 18;

  logic               slow_clock;
  logic               reset;
  logic               start;
  logic [CARD_W-1:0]  pcard3_out;
  logic [SCORE_W-1:0] pscore_out;
  logic [SCORE_W-1:0] dscore_out;
  logic betenabled, load_pcard1, load_pcard2, load_pcard3;
  logic load_dcard1, load_dcard2, load_dcard3, updatebalanceenable;
  logic player_win_light, dealer_win_light, round_done;
  state_e dbg_state;

  baccarat_fsm dut (
    .slow_clock          (slow_clock),
    .reset               (reset),
    .start               (start),
`ifdef BACCARAT_STEP_EN
    .step                (1'b1),
`endif
    .pcard3_out          (pcard3_out),
    .pscore_out          (pscore_out),
    .dscore_out          (dscore_out),
    .betenabled          (betenabled),
    .load_pcard1         (load_pcard1),
    .load_pcard2         (load_pcard2),
    .load_pcard3         (load_pcard3),
    .load_dcard1         (load_dcard1),
    .load_dcard2         (load_dcard2),
    .load_dcard3         (load_dcard3),
    .updatebalanceenable (updatebalanceenable),
    .player_win_light    (player_win_light),
    .dealer_win_light    (dealer_win_light),
    .round_done          (round_done),
    .dbg_state           (dbg_state)
  );

  // ---------------- clock ----------------
  initial slow_clock = 1'b0;
  always #5 slow_clock = ~slow_clock;

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [W-1:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Record: {pl, dl, bet, p1, d1, p2, d2, p3, d3, upd}, counts are 2 bits each.
  function automatic logic [W-1:0] mk_exp(input logic pl, input logic dl,
                                          input logic [1:0] p3n, input logic [1:0] d3n);
    return {pl, dl, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1, p3n, d3n, 2'd1};
  endfunction

  function automatic logic [1:0] sat_inc(input logic [1:0] c, input logic en);
    if (en && c != 2'd3) return c + 2'd1;
    return c;
  endfunction

  // ---------------- datapath stand-in ----------------
  logic [SCORE_W-1:0] cur_p2, cur_d2, cur_p3, cur_d3;
  logic [CARD_W-1:0]  cur_rank;
  logic p_drawn, d_drawn;

  // Scores follow the loads one cycle later, as the real datapath does.
  always @(negedge slow_clock) begin
    if (reset || betenabled) begin
      p_drawn = 1'b0;
      d_drawn = 1'b0;
    end
    if (load_pcard3) p_drawn = 1'b1;
    if (load_dcard3) d_drawn = 1'b1;
    pscore_out = p_drawn ? cur_p3 : cur_p2;
    dscore_out = d_drawn ? cur_d3 : cur_d2;
    pcard3_out = p_drawn ? cur_rank : '0;
  end

  // ---------------- monitor ----------------
  logic [1:0] c_bet, c_p1, c_d1, c_p2, c_d2, c_p3, c_d3, c_upd;
  logic prev_done;

  always @(negedge slow_clock) begin
    logic [W-1:0] obs;
    logic [W-1:0] exp;
    if (reset || dbg_state == S_IDLE) begin
      {c_bet, c_p1, c_d1, c_p2, c_d2, c_p3, c_d3, c_upd} = '0;
      prev_done = 1'b0;
    end else begin
      c_bet = sat_inc(c_bet, betenabled);
      c_p1  = sat_inc(c_p1, load_pcard1);
      c_d1  = sat_inc(c_d1, load_dcard1);
      c_p2  = sat_inc(c_p2, load_pcard2);
      c_d2  = sat_inc(c_d2, load_dcard2);
      c_p3  = sat_inc(c_p3, load_pcard3);
      c_d3  = sat_inc(c_d3, load_dcard3);
      c_upd = sat_inc(c_upd, updatebalanceenable);
      if (betenabled)
        chk("lights_clear_in_bet", {player_win_light, dealer_win_light}, 2'b00);
      if (load_pcard1 | load_pcard2 | load_pcard3 | load_dcard1 | load_dcard2 | load_dcard3)
        chk("single_load", $countones({load_pcard1, load_pcard2, load_pcard3,
                                       load_dcard1, load_dcard2, load_dcard3}), 1);
      if (round_done && !prev_done) begin
        obs = {player_win_light, dealer_win_light, c_bet, c_p1, c_d1, c_p2, c_d2, c_p3, c_d3, c_upd};
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_round: got %0h expected none", obs);
        end else begin
          exp = exp_q.pop_front();
          chk("round_lights",  obs[17:16], exp[17:16]);
          chk("round_loads",   obs[13:2],  exp[13:2]);
          chk("round_bet_upd", {obs[15:14], obs[1:0]}, {exp[15:14], exp[1:0]});
        end
        {c_bet, c_p1, c_d1, c_p2, c_d2, c_p3, c_d3, c_upd} = '0;
      end
      prev_done = round_done;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_round(input logic [3:0] p2, input logic [3:0] d2, input logic [3:0] rank,
                           input logic [3:0] p3, input logic [3:0] d3,
                           input logic pl, input logic dl,
                           input logic [1:0] p3n, input logic [1:0] d3n);
    cur_p2 = p2; cur_d2 = d2; cur_rank = rank; cur_p3 = p3; cur_d3 = d3;
    exp_q.push_back(mk_exp(pl, dl, p3n, d3n));
  endtask

  task automatic wait_done();
    int n = 0;
    while (!round_done && n < 60) begin
      @(negedge slow_clock);
      n++;
    end
    chk("round_done_reached", round_done, 1'b1);
  endtask

  task automatic play();
    @(negedge slow_clock) start = 1'b1;
    @(negedge slow_clock) start = 1'b0;
    wait_done();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_bet"},    betenabled, 1'b0);
    chk({tag, "_loads"},  {load_pcard1, load_pcard2, load_pcard3,
                           load_dcard1, load_dcard2, load_dcard3}, 6'b0);
    chk({tag, "_upd"},    updatebalanceenable, 1'b0);
    chk({tag, "_lights"}, {player_win_light, dealer_win_light}, 2'b00);
    chk({tag, "_done"},   round_done, 1'b0);
    chk({tag, "_state"},  32'(dbg_state), 32'(S_IDLE));
  endtask

  // Sweep tables: dealer 3..6 against ranks 8,4,6,Q; bit 3 = first rank.
  logic [3:0] rank_tab [0:3] = '{4'd8, 4'd4, 4'd6, 4'd12};
  logic [3:0] draw_tab [0:3] = '{4'b0111, 4'b0110, 4'b0110, 4'b0010};

  // ---------------- main sequence ----------------
  initial begin
    reset = 1'b1;
    start = 1'b0;
    cur_p2 = '0; cur_d2 = '0; cur_p3 = '0; cur_d3 = '0; cur_rank = '0;
    repeat (2) @(posedge slow_clock);
    @(negedge slow_clock);
    chk_all_zero("reset");
    reset = 1'b0;

    // Natural: player 8 vs dealer 3.
    set_round(4'd8, 4'd3, 4'd0, 4'd8, 4'd3, 1'b1, 1'b0, 2'd0, 2'd0);
    play();
    // Natural for dealer: player 5 vs dealer 9.
    set_round(4'd5, 4'd9, 4'd0, 4'd5, 4'd9, 1'b0, 1'b1, 2'd0, 2'd0);
    play();
    // Player stands on 6, dealer 4 draws to 9.
    set_round(4'd6, 4'd4, 4'd0, 4'd6, 4'd9, 1'b0, 1'b1, 2'd0, 2'd1);
    play();
    // Stand/stand tie at 7.
    set_round(4'd7, 4'd7, 4'd0, 4'd7, 4'd7, 1'b1, 1'b1, 2'd0, 2'd0);
    play();
    // Dealer 2 always draws (even against an 8), finishes 2 vs player 5.
    set_round(4'd5, 4'd2, 4'd8, 4'd5, 4'd2, 1'b1, 1'b0, 2'd1, 2'd1);
    play();
    // Dealer 7 stands at BANKER; player draws to 7 -> tie.
    set_round(4'd0, 4'd7, 4'd4, 4'd7, 4'd7, 1'b1, 1'b1, 2'd1, 2'd0);
    play();

    // Banker table sweep: player 0 draws to 0, dealer to 9 if it draws.
    for (int di = 0; di < 4; di++) begin
      for (int ri = 0; ri < 4; ri++) begin
        set_round(4'd0, 4'(di + 3), rank_tab[ri], 4'd0, 4'd9, 1'b0, 1'b1,
                  2'd1, {1'b0, draw_tab[di][3-ri]});
        play();
      end
    end

    // Reset in DEAL_P2, then a fresh round straight out of IDLE.
    begin
      int n = 0;
      @(negedge slow_clock) start = 1'b1;
      @(negedge slow_clock) start = 1'b0;
      while (!load_pcard2 && n < 20) begin
        @(negedge slow_clock);
        n++;
      end
      chk("reached_deal_p2", 32'(dbg_state), 32'(S_DEAL_P2));
      reset = 1'b1;
      @(posedge slow_clock);
      #1;
      chk_all_zero("midreset");
      @(negedge slow_clock);
      reset = 1'b0;
      set_round(4'd9, 4'd1, 4'd0, 4'd9, 4'd1, 1'b1, 1'b0, 2'd0, 2'd0);
      start = 1'b1;
      @(posedge slow_clock);
      #1;
      chk("bet_after_reset", betenabled, 1'b1);
      chk("state_after_reset", 32'(dbg_state), 32'(S_BET));
      @(negedge slow_clock) start = 1'b0;
      wait_done();
    end

    // Back-to-back: start held through DONE; player 8 wins, then dealer 9 wins.
    set_round(4'd8, 4'd2, 4'd0, 4'd8, 4'd2, 1'b1, 1'b0, 2'd0, 2'd0);
    @(negedge slow_clock) start = 1'b1;
    @(negedge slow_clock);
    wait_done();
    set_round(4'd3, 4'd9, 4'd0, 4'd3, 4'd9, 1'b0, 1'b1, 2'd0, 2'd0);
    @(negedge slow_clock);
    chk("b2b_bet_state", 32'(dbg_state), 32'(S_BET));
    wait_done();
    start = 1'b0;
    repeat (3) @(negedge slow_clock);
    chk("b2b_stays_done", round_done, 1'b1);

    chk("exp_q_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Global watchdog.
  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
